char2bin: RTL and testbench

Line-oriented ASCII-hex parser on the UART receive path, the inverse of `bin2char`. Consumes bytes from `uart` (`rx_vld`/`rx_data`), accumulates hex digits into a right-aligned binary word, and on end-of-line emits one word-valid pulse. The output feeds `udp_tx_machine` (`tx_udp_dvld`/`tx_udp_data`/`tx_udp_go`), so a typed line becomes a UDP payload. Malformed lines are reported once and then discarded up to the next end-of-line.

---
 rtl/char2bin_pkg.sv | 40 ++++
 rtl/char2bin.sv | 121 ++++++++++++
 tb/tb_char2bin.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/char2bin_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | char2bin_pkg                                                       |
// | Shared types, character constants and hex classifier for char2bin. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package char2bin_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      DISCARD = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_BADCHAR  = 2'd1,
      ERR_OVERFLOW = 2'd2
   } err_t;

   localparam logic [7:0] CH_CR  = 8'h0D;
   localparam logic [7:0] CH_LF  = 8'h0A;
   localparam logic [7:0] CH_SP  = 8'h20;
   localparam logic [7:0] CH_TAB = 8'h09;

   // Returns {is_hex, nibble}; nibble is zero when the byte is not a hex digit.
   function automatic logic [4:0] hex2nib(input logic [7:0] c);
      logic [4:0] r;
      r = 5'd0;
      if (c >= 8'h30 && c <= 8'h39)
         r = {1'b1, 4'(c - 8'h30)};
      else if (c >= 8'h41 && c <= 8'h46)
         r = {1'b1, 4'(c - 8'h37)};
      else if (c >= 8'h61 && c <= 8'h66)
         r = {1'b1, 4'(c - 8'h57)};
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/char2bin.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | char2bin                                                           |
// | Line-oriented ASCII-hex parser: hex digits in, one word per line.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module char2bin
   import char2bin_pkg::*;
#(
   parameter int NDIG = 8
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       char_vld,
   input  logic [7:0]                 char_data,
   output logic                       word_vld,
   output logic [4*NDIG-1:0]          word_data,
   output logic [$clog2(NDIG+1)-1:0]  word_ndig,
   output logic                       err_vld,
   output logic [1:0]                 err_code,
   output logic                       in_line
);

   localparam int W  = 4 * NDIG;
   localparam int CW = $clog2(NDIG + 1);
   localparam logic [CW-1:0] c_ndig = CW'(NDIG);
   localparam logic [CW-1:0] c_one  = CW'(1);

   state_t          r_state;
   logic [W-1:0]    r_acc;
   logic [CW-1:0]   r_cnt;

   logic [4:0]      w_cls;
   logic            w_is_hex;
   logic [3:0]      w_nib;
   logic            w_ws;
   logic            w_eol;

   always_comb begin
      w_cls    = hex2nib(char_data);
      w_is_hex = w_cls[4];
      w_nib    = w_cls[3:0];
      w_ws     = (char_data == CH_SP) || (char_data == CH_TAB);
      w_eol    = (char_data == CH_CR) || (char_data == CH_LF);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= IDLE;
         r_acc     <= '0;
         r_cnt     <= '0;
         word_vld  <= 1'b0;
         word_data <= '0;
         word_ndig <= '0;
         err_vld   <= 1'b0;
         err_code  <= ERR_NONE;
         in_line   <= 1'b0;
      end else begin
         word_vld <= 1'b0;
         err_vld  <= 1'b0;
         if (char_vld) begin
            case (r_state)
               IDLE: begin
                  // Whitespace and EOL are ignored so CR LF and blank lines stay silent.
                  if (w_is_hex) begin
                     r_acc   <= W'(w_nib);
                     r_cnt   <= c_one;
                     r_state <= ACCUM;
                     in_line <= 1'b1;
                  end else if (!w_ws && !w_eol) begin
                     err_vld  <= 1'b1;
                     err_code <= ERR_BADCHAR;
                     r_state  <= DISCARD;
                     in_line  <= 1'b1;
                  end
               end
               ACCUM: begin
                  if (w_is_hex) begin
                     if (r_cnt == c_ndig) begin
                        err_vld  <= 1'b1;
                        err_code <= ERR_OVERFLOW;
                        r_state  <= DISCARD;
                     end else begin
                        r_acc <= (r_acc << 4) | W'(w_nib);
                        r_cnt <= r_cnt + c_one;
                     end
                  end else if (w_eol) begin
                     word_vld  <= 1'b1;
                     word_data <= r_acc;
                     word_ndig <= r_cnt;
                     r_acc     <= '0;
                     r_cnt     <= '0;
                     r_state   <= IDLE;
                     in_line   <= 1'b0;
                  end else if (!w_ws) begin
                     err_vld  <= 1'b1;
                     err_code <= ERR_BADCHAR;
                     r_state  <= DISCARD;
                  end
               end
               DISCARD: begin
                  if (w_eol) begin
                     r_acc   <= '0;
                     r_cnt   <= '0;
                     r_state <= IDLE;
                     in_line <= 1'b0;
                  end
               end
               default: begin
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= IDLE;
                  in_line <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_char2bin.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_char2bin                                                        |
// | Directed stimulus with a queue-based scoreboard for char2bin.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_char2bin;

   logic        clk;
   logic        resetn;
   logic        char_vld;
   logic [7:0]  char_data;
   logic        word_vld;
   logic [31:0] word_data;
   logic [3:0]  word_ndig;
   logic        err_vld;
   logic [1:0]  err_code;
   logic        in_line;

   char2bin #(.NDIG(8)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .char_vld  (char_vld),
      .char_data (char_data),
      .word_vld  (word_vld),
      .word_data (word_data),
      .word_ndig (word_ndig),
      .err_vld   (err_vld),
      .err_code  (err_code),
      .in_line   (in_line)
   );

   typedef struct {
      bit          is_err;
      logic [31:0] data;
      logic [3:0]  ndig;
      logic [1:0]  code;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t mk_word(input logic [31:0] d, input logic [3:0] n);
      exp_t e;
      e.is_err = 1'b0; e.data = d; e.ndig = n; e.code = 2'd0; e.cyc = 0;
      return e;
   endfunction

   function automatic exp_t mk_err(input logic [1:0] c);
      exp_t e;
      e.is_err = 1'b1; e.data = '0; e.ndig = '0; e.code = c; e.cyc = 0;
      return e;
   endfunction

   // Drives one byte per cycle; the byte at index trig is expected to raise e one cycle later.
   task automatic send(input string s, input int trig, input exp_t e);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk);
         char_vld  = 1'b1;
         char_data = s[i];
         if (i == trig) begin
            e.cyc = cyc + 1;
            sb.push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         char_vld  = 1'b0;
         char_data = 8'h00;
      end
   endtask

   // Monitor: every output pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (resetn) begin
         if (word_vld && err_vld)
            check("word_err_overlap", 64'(1), 64'(0));
         if (word_vld || err_vld) begin
            if (sb.size() == 0) begin
               check("unexpected_pulse", {62'd0, word_vld, err_vld}, 64'(0));
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("pulse_cycle", 64'(cyc), 64'(e.cyc));
               if (e.is_err) begin
                  check("pulse_kind_err", 64'(err_vld), 64'(1));
                  check("err_code", 64'(err_code), 64'(e.code));
               end else begin
                  check("pulse_kind_word", 64'(word_vld), 64'(1));
                  check("word_data", 64'(word_data), 64'(e.data));
                  check("word_ndig", 64'(word_ndig), 64'(e.ndig));
               end
            end
         end
      end
   end

   exp_t none;
   string one;

   initial begin
      none      = mk_word('0, '0);
      char_vld  = 1'b0;
      char_data = 8'h00;
      resetn    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_word_vld",  64'(word_vld),  64'(0));
      check("rst_err_vld",   64'(err_vld),   64'(0));
      check("rst_in_line",   64'(in_line),   64'(0));
      check("rst_word_data", 64'(word_data), 64'(0));
      check("rst_word_ndig", 64'(word_ndig), 64'(0));
      check("rst_err_code",  64'(err_code),  64'(0));
      resetn = 1'b1;

      // CR ends the word; the LF that follows produces nothing.
      send("DEADBEEF\r\n", 8, mk_word(32'hDEADBEEF, 4'd8));
      idle(3);

      // Back-to-back lines, second with leading and inner whitespace.
      send("a5\n", 2, mk_word(32'h000000A5, 4'd2));
      send(" 1 2\n", 4, mk_word(32'h00000012, 4'd2));
      send("DEAD\tBEEF\n", 9, mk_word(32'hDEADBEEF, 4'd8));
      idle(2);

      // Bad character mid-line, then the rest of the line is dropped.
      send("12G45\n", 2, mk_err(2'd1));
      send("x!9\n", 0, mk_err(2'd1));
      send("f0\n", 2, mk_word(32'h000000F0, 4'd2));
      send("7\n", 1, mk_word(32'h00000007, 4'd1));
      idle(2);

      // Ninth digit overflows; the held word stays at 7.
      send("123456789\n", 8, mk_err(2'd2));
      idle(2);
      check("ovf_word_hold", 64'(word_data), 64'(32'h7));
      check("ovf_ndig_hold", 64'(word_ndig), 64'(1));
      check("ovf_code_hold", 64'(err_code),  64'(2));

      // Blank lines: no pulses and in_line never rises.
      for (int i = 0; i < 4; i++) begin
         one = (i % 2 == 0) ? "\r" : "\n";
         send(one, -1, none);
         idle(1);
         check("blank_in_line", 64'(in_line), 64'(0));
      end
      idle(2);

      // Reset in the middle of a line discards the partial word.
      send("ABC", -1, none);
      idle(1);
      check("mid_in_line", 64'(in_line), 64'(1));
      resetn = 1'b0;
      #1;
      check("mid_rst_word_data", 64'(word_data), 64'(0));
      check("mid_rst_word_ndig", 64'(word_ndig), 64'(0));
      check("mid_rst_err_code",  64'(err_code),  64'(0));
      check("mid_rst_in_line",   64'(in_line),   64'(0));
      check("mid_rst_pulses",    64'({word_vld, err_vld}), 64'(0));
      idle(2);
      resetn = 1'b1;
      send("\n", -1, none);
      idle(4);
      check("post_rst_in_line", 64'(in_line), 64'(0));

      // Next line after reset starts cleanly.
      send("c\n", 1, mk_word(32'h0000000C, 4'd1));
      idle(4);

      check("sb_drained", 64'(sb.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
